// File: rtl/cisc_timing_pkg.sv
// Shared timing definitions for the CISC core phase sequencer: state
// encoding, pattern-mode constants and the step-to-vector helper.
package cisc_timing_pkg;

    localparam int unsigned MAX_PHASES = 16;
    localparam int unsigned STEP_WIDTH = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic PAT_THERM  = 1'b0;
    localparam logic PAT_ONEHOT = 1'b1;

    // Phase vector for a given step: thermometer sets the low 'step' bits,
    // one-hot sets only bit 'step'. Bits at or above num_phases stay clear.
    function automatic logic [MAX_PHASES-1:0] phase_pattern(
        input logic [STEP_WIDTH-1:0] step,
        input logic                  onehot,
        input int unsigned           num_phases
    );
        logic [MAX_PHASES-1:0] vec;
        vec = '0;
        for (int unsigned i = 0; i < MAX_PHASES; i++) begin
            if (i < num_phases) begin
                if (onehot == PAT_THERM) begin
                    vec[i] = (i < 32'(step));
                end else begin
                    vec[i] = (i == 32'(step));
                end
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/phase_sequence_generator_if.sv
// Control/status bundle between the core sequencer and the phase generator.
interface phase_sequence_generator_if #(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned DIV_WIDTH  = 8,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_PHASES + 1)
);

    logic                  Start;
    logic                  Stop;
    logic                  Hold;
    logic                  SingleShot;
    logic                  OneHot;
    logic [DIV_WIDTH-1:0]  DivRatio;
    logic [NUM_PHASES-1:0] ClockSource;
    logic [IDX_WIDTH-1:0]  PhaseIndex;
    logic                  StepStrobe;
    logic                  CycleDone;
    logic                  Busy;

    // Controller side: issues commands, observes the phase vector.
    modport master (
        output Start, Stop, Hold, SingleShot, OneHot, DivRatio,
        input  ClockSource, PhaseIndex, StepStrobe, CycleDone, Busy
    );

    // Generator side.
    modport slave (
        input  Start, Stop, Hold, SingleShot, OneHot, DivRatio,
        output ClockSource, PhaseIndex, StepStrobe, CycleDone, Busy
    );

endinterface

// File: rtl/phase_sequence_generator_step_divider.sv
// Step-length divider: counts 0..Ratio while enabled and flags the
// cycle on which the current step should advance.
module step_divider #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 PLClock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 Hold,
    input  logic [DIV_WIDTH-1:0] Ratio,
    output logic                 Tick
);

    logic [DIV_WIDTH-1:0] count;

    // Hold wins over a terminal count; the counter never passes Ratio.
    assign Tick = Enable && !Hold && (count == Ratio);

    // Step-length counter, cleared outside RUN and on every tick.
    always_ff @(posedge PLClock) begin
        if (Reset || !Enable) begin
            count <= '0;
        end else if (Tick) begin
            count <= '0;
        end else if (!Hold) begin
            count <= count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/phase_sequence_generator.sv
// Programmable multi-phase enable generator for the CISC core datapath.
// Walks a thermometer or one-hot pattern, one step per divider tick,
// in free-run or single-shot mode with graceful stop and hold.
module phase_sequence_generator
    import cisc_timing_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned DIV_WIDTH  = 8,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_PHASES + 1)
) (
    input logic                        PLClock,
    input logic                        Reset,
    phase_sequence_generator_if.slave  bus
);

    localparam logic [0:0] S_IDLE = 1'(IDLE);
    localparam logic [0:0] S_RUN  = 1'(RUN);

    localparam logic [IDX_WIDTH-1:0] LAST_THERM  = IDX_WIDTH'(NUM_PHASES);
    localparam logic [IDX_WIDTH-1:0] LAST_ONEHOT = IDX_WIDTH'(NUM_PHASES - 1);

    logic [0:0]            state,      state_n;
    logic [IDX_WIDTH-1:0]  step,       step_n;
    logic [NUM_PHASES-1:0] phase_vec,  phase_vec_n;
    logic                  strobe,     strobe_n;
    logic                  done,       done_n;
    logic                  busy,       busy_n;
    logic                  single_lat, single_lat_n;
    logic                  onehot_lat, onehot_lat_n;
    logic [DIV_WIDTH-1:0]  ratio_lat,  ratio_lat_n;
    logic                  stop_pend,  stop_pend_n;

    logic                  tick;
    logic                  run_en;
    logic [IDX_WIDTH-1:0]  last_step;
    logic [IDX_WIDTH-1:0]  step_inc;
    logic                  finish;

    assign run_en    = (state == S_RUN);
    assign last_step = (onehot_lat == PAT_ONEHOT) ? LAST_ONEHOT : LAST_THERM;
    assign step_inc  = step + IDX_WIDTH'(1);
    // A Stop arriving on the final tick still ends the sequence at this wrap.
    assign finish    = single_lat || stop_pend || bus.Stop;

    step_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_divider (
        .PLClock (PLClock),
        .Reset   (Reset),
        .Enable  (run_en),
        .Hold    (bus.Hold),
        .Ratio   (ratio_lat),
        .Tick    (tick)
    );

    // State and output registers.
    always_ff @(posedge PLClock) begin
        if (Reset) begin
            state      <= S_IDLE;
            step       <= '0;
            phase_vec  <= '0;
            strobe     <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            single_lat <= 1'b0;
            onehot_lat <= 1'b0;
            ratio_lat  <= '0;
            stop_pend  <= 1'b0;
        end else begin
            state      <= state_n;
            step       <= step_n;
            phase_vec  <= phase_vec_n;
            strobe     <= strobe_n;
            done       <= done_n;
            busy       <= busy_n;
            single_lat <= single_lat_n;
            onehot_lat <= onehot_lat_n;
            ratio_lat  <= ratio_lat_n;
            stop_pend  <= stop_pend_n;
        end
    end

    // Next-state and next-output logic for the IDLE/RUN sequencer.
    always_comb begin
        state_n      = state;
        step_n       = step;
        phase_vec_n  = phase_vec;
        strobe_n     = 1'b0;
        done_n       = 1'b0;
        busy_n       = busy;
        single_lat_n = single_lat;
        onehot_lat_n = onehot_lat;
        ratio_lat_n  = ratio_lat;
        stop_pend_n  = stop_pend;

        case (state)
            S_IDLE: begin
                if (bus.Start) begin
                    state_n      = S_RUN;
                    single_lat_n = bus.SingleShot;
                    onehot_lat_n = bus.OneHot;
                    ratio_lat_n  = bus.DivRatio;
                    stop_pend_n  = 1'b0;
                    step_n       = '0;
                    phase_vec_n  = NUM_PHASES'(phase_pattern(STEP_WIDTH'(0), bus.OneHot, NUM_PHASES));
                    busy_n       = 1'b1;
                end
            end

            S_RUN: begin
                if (bus.Stop) begin
                    stop_pend_n = 1'b1;
                end
                if (tick) begin
                    strobe_n = 1'b1;
                    if (step == last_step) begin
                        done_n = 1'b1;
                        if (finish) begin
                            state_n      = S_IDLE;
                            step_n       = '0;
                            phase_vec_n  = '0;
                            busy_n       = 1'b0;
                            stop_pend_n  = 1'b0;
                            single_lat_n = 1'b0;
                            onehot_lat_n = 1'b0;
                            ratio_lat_n  = '0;
                        end else begin
                            // Free-run wrap: only the step length is re-sampled.
                            step_n      = '0;
                            ratio_lat_n = bus.DivRatio;
                            phase_vec_n = NUM_PHASES'(phase_pattern(STEP_WIDTH'(0), onehot_lat, NUM_PHASES));
                        end
                    end else begin
                        step_n      = step_inc;
                        phase_vec_n = NUM_PHASES'(phase_pattern(STEP_WIDTH'(step_inc), onehot_lat, NUM_PHASES));
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.ClockSource = phase_vec;
    assign bus.PhaseIndex  = step;
    assign bus.StepStrobe  = strobe;
    assign bus.CycleDone   = done;
    assign bus.Busy        = busy;

endmodule

// File: tb/tb_phase_sequence_generator.sv
// Bench for phase_sequence_generator: directed scenarios followed by a
// randomized run, all cycles checked against a behavioural model.
module tb_phase_sequence_generator;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    phase_sequence_generator_if #(.NUM_PHASES(NP), .DIV_WIDTH(DW)) bus ();

    phase_sequence_generator #(
        .NUM_PHASES (NP),
        .DIV_WIDTH  (DW)
    ) dut (
        .PLClock (clk),
        .Reset   (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: running flag, current step, cycles spent in step.
    int m_run, m_k, m_cnt, m_single, m_onehot, m_ratio, m_pend;
    int e_cs, e_idx, e_strobe, e_done, e_busy;

    logic [3:0] therm_seq [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int last;
        if (rst) begin
            m_run = 0; m_k = 0; m_cnt = 0; m_single = 0; m_onehot = 0;
            m_ratio = 0; m_pend = 0; e_strobe = 0; e_done = 0;
        end else if (m_run == 0) begin
            e_strobe = 0;
            e_done   = 0;
            if (bus.Start) begin
                m_run    = 1;
                m_single = int'(bus.SingleShot);
                m_onehot = int'(bus.OneHot);
                m_ratio  = int'(bus.DivRatio);
                m_k      = 0;
                m_cnt    = 0;
                m_pend   = 0;
            end
        end else begin
            e_strobe = 0;
            e_done   = 0;
            if (bus.Stop) m_pend = 1;
            if (!bus.Hold) begin
                if (m_cnt < m_ratio) begin
                    m_cnt++;
                end else begin
                    m_cnt    = 0;
                    e_strobe = 1;
                    last     = (m_onehot != 0) ? int'(NP) - 1 : int'(NP);
                    if (m_k < last) begin
                        m_k++;
                    end else begin
                        e_done = 1;
                        m_k    = 0;
                        if (m_single != 0 || m_pend != 0) begin
                            m_run  = 0;
                            m_pend = 0;
                        end else begin
                            m_ratio = int'(bus.DivRatio);
                        end
                    end
                end
            end
        end
        e_busy = m_run;
        e_idx  = (m_run != 0) ? m_k : 0;
        if (m_run == 0)        e_cs = 0;
        else if (m_onehot != 0) e_cs = 1 << m_k;
        else                   e_cs = (1 << m_k) - 1;
    endtask

    // One clock: advance the model at the edge, compare just after it.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("cs",     32'(bus.ClockSource), e_cs);
        chk("idx",    32'(bus.PhaseIndex),  e_idx);
        chk("strobe", 32'(bus.StepStrobe),  e_strobe);
        chk("done",   32'(bus.CycleDone),   e_done);
        chk("busy",   32'(bus.Busy),        e_busy);
    endtask

    task automatic run_until_step(input int k);
        for (int n = 0; n < 40; n++) begin
            if (m_run != 0 && m_k == k) break;
            cycle();
        end
        chk("reach_step", 32'(bus.PhaseIndex), k);
    endtask

    task automatic start_seq(input logic single, input logic onehot, input int ratio);
        bus.SingleShot = single;
        bus.OneHot     = onehot;
        bus.DivRatio   = DW'(ratio);
        bus.Start      = 1'b1;
        cycle();
        bus.Start      = 1'b0;
    endtask

    task automatic drain();
        bus.Stop = 1'b1;
        cycle();
        bus.Stop = 1'b0;
        for (int n = 0; n < 40; n++) cycle();
        chk("drained_busy", 32'(bus.Busy), 0);
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        bus.Start = 1'b0; bus.Stop = 1'b0; bus.Hold = 1'b0;
        bus.SingleShot = 1'b0; bus.OneHot = 1'b0; bus.DivRatio = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("reset_cs",   32'(bus.ClockSource), 0);
        chk("reset_busy", 32'(bus.Busy), 0);

        // Thermometer free-run, one cycle per step.
        start_seq(1'b0, 1'b0, 0);
        chk("t1_step0", 32'(bus.ClockSource), 0);
        for (int j = 1; j < 11; j++) begin
            cycle();
            chk("t1_seq",  32'(bus.ClockSource), 32'(therm_seq[j % 5]));
            chk("t1_done", 32'(bus.CycleDone), (j % 5 == 0) ? 1 : 0);
        end
        drain();

        // One-hot single shot, three cycles per step.
        start_seq(1'b1, 1'b1, 2);
        chk("t2_step0", 32'(bus.ClockSource), 1);
        dones = 0;
        for (int n = 0; n < 16; n++) begin
            cycle();
            if (bus.CycleDone) dones++;
        end
        chk("t2_dones", 32'(dones), 1);
        chk("t2_busy",  32'(bus.Busy), 0);

        // Graceful stop requested during step 2.
        start_seq(1'b0, 1'b0, 1);
        run_until_step(2);
        bus.Stop = 1'b1;
        cycle();
        bus.Stop = 1'b0;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (bus.CycleDone) dones++;
        end
        chk("t3_dones", 32'(dones), 1);
        chk("t3_idle",  32'(bus.ClockSource), 0);

        // Hold for five cycles while step 3 is showing.
        start_seq(1'b0, 1'b0, 0);
        run_until_step(3);
        bus.Hold = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("t4_hold_cs",  32'(bus.ClockSource), 32'h7);
            chk("t4_hold_idx", 32'(bus.PhaseIndex), 3);
            chk("t4_hold_stb", 32'(bus.StepStrobe), 0);
        end
        bus.Hold = 1'b0;
        cycle();
        chk("t4_resume", 32'(bus.ClockSource), 32'hF);
        drain();

        // Reset mid-run with a coincident Start, then a clean restart.
        start_seq(1'b0, 1'b0, 0);
        run_until_step(3);
        rst = 1'b1;
        bus.Start = 1'b1;
        cycle();
        chk("t5_cs",   32'(bus.ClockSource), 0);
        chk("t5_idx",  32'(bus.PhaseIndex), 0);
        chk("t5_busy", 32'(bus.Busy), 0);
        rst = 1'b0;
        bus.Start = 1'b0;
        cycle();
        chk("t5_still_idle", 32'(bus.Busy), 0);
        start_seq(1'b0, 1'b0, 0);
        chk("t5_restart_busy", 32'(bus.Busy), 1);
        chk("t5_restart_idx",  32'(bus.PhaseIndex), 0);
        drain();

        // Ratio changed mid-sequence takes effect only after the wrap.
        start_seq(1'b0, 1'b0, 0);
        cycle();
        bus.DivRatio = DW'(3);
        for (int j = 2; j < 5; j++) begin
            cycle();
            chk("t6_fast", 32'(bus.ClockSource), 32'(therm_seq[j]));
        end
        cycle();
        for (int n = 0; n < 4; n++) begin
            chk("t6_slow", 32'(bus.ClockSource), 0);
            cycle();
        end
        chk("t6_next", 32'(bus.ClockSource), 1);
        for (int n = 0; n < 20; n++) cycle();
        drain();

        // Randomized control traffic.
        for (int n = 0; n < 600; n++) begin
            rst            = ($urandom_range(0, 63) == 0);
            bus.Start      = ($urandom_range(0, 3) == 0);
            bus.Stop       = ($urandom_range(0, 15) == 0);
            bus.Hold       = ($urandom_range(0, 7) == 0);
            bus.SingleShot = 1'($urandom_range(0, 1));
            bus.OneHot     = 1'($urandom_range(0, 1));
            bus.DivRatio   = DW'($urandom_range(0, 3));
            cycle();
        end
        rst = 1'b0;
        bus.Start = 1'b0; bus.Hold = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_sequence_generator.md
Name: phase_sequence_generator

Overview:
- Parametrised successor to the fixed 4-phase clock-source generator.
- Produces an N-bit phase/enable vector from PLClock. Each step lasts a runtime-programmable number of cycles.
- Two pattern modes: thermometer and one-hot ring. Two run modes: free-run and single-shot.
- Supports start, graceful stop and hold. Gates the multi-phase datapath/control sequencing of the CISC core.

Parameters:
- NUM_PHASES, 4, number of phase outputs; legal 2..16.
- DIV_WIDTH, 8, width of the step-length divider (DivRatio).
- IDX_WIDTH, $clog2(NUM_PHASES+1), width of PhaseIndex (derived; do not override).

Ports:
- PLClock  input  1  single system clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  level-sampled; begins a sequence when in IDLE.
- Stop  input  1  requests a graceful stop at the end of the current sequence.
- Hold  input  1  freezes the divider and step while high.
- SingleShot  input  1  1 = run one sequence then stop; 0 = free-run. Latched at Start.
- OneHot  input  1  1 = one-hot ring pattern; 0 = thermometer. Latched at Start.
- DivRatio  input  DIV_WIDTH  step length minus 1, in cycles.
- ClockSource  output  NUM_PHASES  registered phase vector.
- PhaseIndex  output  IDX_WIDTH  current step number.
- StepStrobe  output  1  one-cycle pulse on the cycle a step advances.
- CycleDone  output  1  one-cycle pulse when the last step completes.
- Busy  output  1  high in RUN.

Behaviour:
- Reset (synchronous, active-high) in any state, including mid-sequence. On the next edge:
  - State = IDLE.
  - ClockSource = 0, PhaseIndex = 0, StepStrobe = 0, CycleDone = 0, Busy = 0.
  - Divider = 0; pending-stop flag cleared; latched mode bits cleared.
- FSM has two states, IDLE and RUN.
- IDLE:
  - Outputs as at reset.
  - Start = 1 at edge t latches SingleShot, OneHot and DivRatio, then enters RUN at edge t.
  - Step 0 is visible in the cycle after t.
  - Stop and Hold are ignored in IDLE.
- Step count: LAST = NUM_PHASES for thermometer (steps 0..NUM_PHASES); LAST = NUM_PHASES-1 for one-hot (steps 0..NUM_PHASES-1).
- Patterns for step k:
  - Thermometer: the low k bits are set (k=0 gives all zero; k=NUM_PHASES gives all ones).
  - One-hot: bit k only.
- Divider (RUN only):
  - Counts 0..DivRatioLatched.
  - tick = (count == DivRatioLatched) && !Hold.
  - On tick, count returns to 0 and the step advances. Each step therefore lasts DivRatioLatched+1 cycles.
  - DivRatio = 0 gives an advance every cycle.
- Hold = 1 freezes the divider, step and ClockSource, and suppresses tick. Hold has priority over tick in the same cycle.
- Step advance on tick with step < LAST: step+1; StepStrobe pulses in the following cycle, aligned with the new ClockSource.
- Wrap on tick with step == LAST:
  - CycleDone and StepStrobe pulse.
  - If SingleShot is latched or the pending stop is set: go to IDLE with outputs 0 and Busy = 0.
  - Otherwise: step = 0; DivRatio is re-latched from the input; SingleShot and OneHot are not re-latched.
- Mid-run changes: DivRatio changes are ignored until the next wrap.
- Stop:
  - Stop = 1 in RUN sets the pending-stop flag, which clears on entry to IDLE.
  - Stop on the same cycle as the final tick takes effect at that wrap.
- Start in RUN is ignored. Start held high in IDLE after a stop restarts on the next edge.
- Busy = 1 exactly while in RUN.
- Width rules: all counters are unsigned. PhaseIndex is zero-extended to IDX_WIDTH. The divider counter is DIV_WIDTH bits and cannot overflow, since it compares against the latched ratio.

Decomposition:
- Shared package cisc_timing_pkg:
  - State enum {IDLE, RUN}.
  - Pattern-mode constants PAT_THERM = 0, PAT_ONEHOT = 1.
  - Function phase_pattern(step, onehot, NUM_PHASES) returning the vector.
- One sub-module: step_divider. Parameter DIV_WIDTH; inputs PLClock, Reset, Enable, Hold, Ratio; output Tick.
- The FSM, step counter and pattern register stay in the top module.

Test Plan:
- NUM_PHASES=4, thermometer, free-run, DivRatio=0, Start pulse:
  - ClockSource per cycle: 0000, 0001, 0011, 0111, 1111, 0000, …
  - CycleDone pulses every 5 cycles; Busy = 1.
- One-hot, SingleShot=1, DivRatio=2:
  - Sequence 0001, 0010, 0100, 1000, each held 3 cycles.
  - CycleDone pulses once, then IDLE with ClockSource = 0 and Busy = 0.
- Free-run, DivRatio=1, Stop asserted during step 2:
  - Sequence completes through 1111, CycleDone pulses, then IDLE.
  - No further steps.
- Hold high for 5 cycles during step 3 with DivRatio=0:
  - ClockSource stays 0111 and PhaseIndex stays 3 for 5 cycles; no StepStrobe.
  - Resumes at 1111 after Hold falls.
- Reset mid-run at step 3:
  - Next cycle: ClockSource = 0000, PhaseIndex = 0, Busy = 0.
  - A Start asserted together with Reset is ignored; a later Start restarts from step 0.
- Free-run with DivRatio changed 0→3 mid-sequence:
  - The current sequence keeps 1-cycle steps.
  - After the wrap, steps last 4 cycles.
